// File: rtl/miner_host_ctrl_pkg.sv
// Shared definitions for the miner host controller: network packet format,
// command codes, register addresses and the per-channel state encoding.
package miner_host_ctrl_pkg;

    localparam int mask_length_gp = 3;
    localparam int work_words_gp  = 11;

    typedef enum logic [1:0] {
        NET_OP_NULL = 2'd0,
        NET_OP_REG  = 2'd1,
        NET_OP_BAR  = 2'd2,
        NET_OP_PC   = 2'd3
    } net_op_e;

    typedef struct packed {
        logic [9:0]  net_id;
        logic [1:0]  reserved;
        net_op_e     net_op;
        logic [31:0] net_data;
        logic [15:0] net_addr;
    } net_packet_s;

    localparam logic [9:0]  net_id_gp         = 10'd1;
    localparam logic [31:0] cmd_load_gp       = 32'd1;
    localparam logic [31:0] cmd_nonce_gp      = 32'd2;
    localparam logic [31:0] cmd_found_gp      = 32'd3;
    localparam logic [31:0] bar_mask_gp       = 32'd7;
    localparam logic [31:0] pc_data_gp        = 32'd2;
    localparam logic [15:0] addr_nonce_gp     = 16'd1;
    localparam logic [15:0] addr_work_base_gp = 16'd1;
    localparam logic [15:0] addr_cmd_gp       = 16'd20;
    localparam logic [15:0] addr_bar_gp       = 16'd24;
    localparam logic [15:0] addr_pc_gp        = 16'd0;
    localparam logic [2:0]  barrier_go_gp     = 3'b000;
    localparam logic [2:0]  barrier_found_gp  = 3'b001;

    localparam net_packet_s filler_packet_gp = '{
        net_id:   10'd1,
        reserved: 2'd0,
        net_op:   NET_OP_NULL,
        net_data: 32'hFFFF_FFFE,
        net_addr: 16'd24
    };

    typedef enum logic [3:0] {
        CH_IDLE, CH_BAR, CH_LDWORK, CH_CMD, CH_PC,
        CH_REL, CH_WAIT, CH_SETTLE, CH_LDNONCE, CH_DONE
    } chan_state_e;

    function automatic net_packet_s make_packet(input net_op_e op, input logic [31:0] data,
                                                input logic [15:0] addr);
        make_packet = '{net_id: net_id_gp, reserved: 2'd0, net_op: op,
                        net_data: data, net_addr: addr};
    endfunction

endpackage

// File: rtl/miner_host_chan.sv
// One host channel: loads work into a miner core, then feeds it strided
// nonces until the core reports a hit or the nonce range is exhausted.
module miner_host_chan
    import miner_host_ctrl_pkg::*;
#(
    parameter int          chan_idx_p      = 0,
    parameter int          num_cores_p     = 4,
    parameter int          settle_cycles_p = 2,
    parameter logic [31:0] nonce_base_p    = 32'd0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [32*work_words_gp-1:0] work,
    input  logic [31:0]               nonce_limit,
    input  logic [mask_length_gp-1:0] barrier,
    input  logic                      found_any,
    output net_packet_s               packet,
    output logic                      active,
    output logic                      done,
    output logic                      found_hit,
    output logic                      nonce_issued,
    output logic [31:0]               last_nonce
);

    localparam int settle_w = (settle_cycles_p > 1) ? $clog2(settle_cycles_p) : 1;

    chan_state_e         state_q, state_d;
    logic [3:0]          word_q, word_d;
    logic [settle_w-1:0] settle_q, settle_d;
    logic                found_flag_q, found_flag_d;
    logic [32:0]         next_nonce_q, next_nonce_d;
    logic [31:0]         last_nonce_q, last_nonce_d;
    logic [31:0]         cmd_q, cmd_d;
    net_packet_s         packet_q, packet_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= CH_IDLE;
            packet_q <= filler_packet_gp;
        end else begin
            state_q  <= state_d;
            packet_q <= packet_d;
        end
        word_q       <= word_d;
        settle_q     <= settle_d;
        found_flag_q <= found_flag_d;
        next_nonce_q <= next_nonce_d;
        last_nonce_q <= last_nonce_d;
        cmd_q        <= cmd_d;
    end

    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        settle_d     = settle_q;
        found_flag_d = found_flag_q;
        next_nonce_d = next_nonce_q;
        last_nonce_d = last_nonce_q;
        cmd_d        = cmd_q;
        case (state_q)
            CH_IDLE, CH_DONE: begin
                if (start) begin
                    state_d      = CH_BAR;
                    next_nonce_d = 33'(nonce_base_p) + 33'(chan_idx_p);
                    last_nonce_d = '0;
                    found_flag_d = 1'b0;
                end
            end
            CH_BAR: begin
                state_d = CH_LDWORK;
                word_d  = '0;
            end
            CH_LDWORK: begin
                if (word_q == 4'(work_words_gp - 1)) begin
                    state_d = CH_CMD;
                    cmd_d   = cmd_load_gp;
                end else begin
                    word_d = word_q + 4'd1;
                end
            end
            CH_CMD: state_d = CH_PC;
            CH_PC:  state_d = CH_REL;
            CH_REL: state_d = (cmd_q == cmd_found_gp) ? CH_DONE : CH_WAIT;
            CH_WAIT: begin
                if (barrier == barrier_go_gp || barrier == barrier_found_gp) begin
                    state_d      = CH_SETTLE;
                    settle_d     = '0;
                    found_flag_d = (barrier == barrier_found_gp);
                end
            end
            CH_SETTLE: begin
                if (settle_q == settle_w'(settle_cycles_p - 1)) begin
                    if (found_flag_q) begin
                        state_d = CH_CMD;
                        cmd_d   = cmd_found_gp;
                    // 33-bit compare: a stride that carries past 2^32-1 counts as out of range
                    end else if (found_any || next_nonce_q > {1'b0, nonce_limit}) begin
                        state_d = CH_DONE;
                    end else begin
                        state_d = CH_LDNONCE;
                    end
                end else begin
                    settle_d = settle_q + settle_w'(1);
                end
            end
            CH_LDNONCE: begin
                state_d      = CH_CMD;
                cmd_d        = cmd_nonce_gp;
                last_nonce_d = next_nonce_q[31:0];
                next_nonce_d = next_nonce_q + 33'(num_cores_p);
            end
            default: state_d = CH_IDLE;
        endcase
    end

    // The packet register always holds the packet of the state being entered.
    always_comb begin
        packet_d = filler_packet_gp;
        case (state_d)
            CH_BAR:     packet_d = make_packet(NET_OP_BAR, bar_mask_gp, addr_bar_gp);
            CH_LDWORK:  packet_d = make_packet(NET_OP_REG, work[{word_d, 5'd0} +: 32],
                                               addr_work_base_gp + 16'(word_d));
            CH_CMD:     packet_d = make_packet(NET_OP_REG, cmd_d, addr_cmd_gp);
            CH_PC:      packet_d = make_packet(NET_OP_PC, pc_data_gp, addr_pc_gp);
            CH_LDNONCE: packet_d = make_packet(NET_OP_REG, next_nonce_q[31:0], addr_nonce_gp);
            default:    packet_d = filler_packet_gp;
        endcase
    end

    assign packet       = packet_q;
    assign active       = (state_q != CH_IDLE) && (state_q != CH_DONE);
    assign done         = (state_q == CH_DONE);
    assign found_hit    = (state_q == CH_WAIT) && (barrier == barrier_found_gp);
    assign nonce_issued = (state_q == CH_LDNONCE);
    assign last_nonce   = last_nonce_q;

endmodule

// File: rtl/miner_host_ctrl.sv
// Host controller for an array of miner cores: one channel per core, plus
// job start gating, found-hash arbitration and the tried-nonce counter.
module miner_host_ctrl
    import miner_host_ctrl_pkg::*;
#(
    parameter int          num_cores_p     = 4,
    parameter int          settle_cycles_p = 2,
    parameter logic [31:0] nonce_base_p    = 32'd0
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start_i,
    input  logic [32*work_words_gp-1:0]            work_i,
    input  logic [31:0]                            nonce_limit_i,
    input  logic [num_cores_p*mask_length_gp-1:0]  barrier_flat_i,
    output logic [num_cores_p*$bits(net_packet_s)-1:0] net_packet_flat_o,
    output logic                                   busy_o,
    output logic                                   done_o,
    output logic                                   found_o,
    output logic [31:0]                            found_nonce_o,
    output logic [((num_cores_p > 1) ? $clog2(num_cores_p) : 1)-1:0] found_core_o,
    output logic [31:0]                            nonces_tried_o
);

    localparam int core_w = (num_cores_p > 1) ? $clog2(num_cores_p) : 1;
    localparam int pkt_w  = $bits(net_packet_s);

    logic [num_cores_p-1:0] active, done, found_hit, nonce_issued;
    logic [31:0]            last_nonce [num_cores_p];
    net_packet_s            packet [num_cores_p];
    logic                   start_go;

    logic                   found_q;
    logic [31:0]            found_nonce_q;
    logic [core_w-1:0]      found_core_q;
    logic [31:0]            tried_q;

    logic                   win;
    logic [core_w-1:0]      win_core;
    logic [31:0]            win_nonce;
    logic [4:0]             issued_cnt;
    logic [32:0]            tried_sum;

    assign busy_o   = |active;
    assign done_o   = &done;
    assign start_go = start_i && !busy_o;

    for (genvar c = 0; c < num_cores_p; c++) begin : g_chan
        miner_host_chan #(
            .chan_idx_p      (c),
            .num_cores_p     (num_cores_p),
            .settle_cycles_p (settle_cycles_p),
            .nonce_base_p    (nonce_base_p)
        ) u_chan (
            .clk          (clk),
            .reset        (reset),
            .start        (start_go),
            .work         (work_i),
            .nonce_limit  (nonce_limit_i),
            .barrier      (barrier_flat_i[c*mask_length_gp +: mask_length_gp]),
            .found_any    (found_q),
            .packet       (packet[c]),
            .active       (active[c]),
            .done         (done[c]),
            .found_hit    (found_hit[c]),
            .nonce_issued (nonce_issued[c]),
            .last_nonce   (last_nonce[c])
        );
        assign net_packet_flat_o[c*pkt_w +: pkt_w] = packet[c];
    end

    // Scan from the top so the lowest-numbered reporting channel wins.
    always_comb begin
        win       = 1'b0;
        win_core  = '0;
        win_nonce = '0;
        for (int c = num_cores_p - 1; c >= 0; c--) begin
            if (found_hit[c]) begin
                win       = 1'b1;
                win_core  = core_w'(c);
                win_nonce = last_nonce[c];
            end
        end
    end

    always_comb begin
        issued_cnt = '0;
        for (int c = 0; c < num_cores_p; c++) begin
            issued_cnt = issued_cnt + 5'(nonce_issued[c]);
        end
    end

    assign tried_sum = {1'b0, tried_q} + 33'(issued_cnt);

    always_ff @(posedge clk) begin
        if (!reset || start_go) begin
            found_q       <= 1'b0;
            found_nonce_q <= '0;
            found_core_q  <= '0;
            tried_q       <= '0;
        end else begin
            if (win && !found_q) begin
                found_q       <= 1'b1;
                found_nonce_q <= win_nonce;
                found_core_q  <= win_core;
            end
            tried_q <= tried_sum[32] ? 32'hFFFF_FFFF : tried_sum[31:0];
        end
    end

    assign found_o        = found_q;
    assign found_nonce_o  = found_nonce_q;
    assign found_core_o   = found_core_q;
    assign nonces_tried_o = tried_q;

endmodule
